// File: rtl/tree_sort_controller_pkg.sv
// Shared constants, state encoding and helpers for the six-word tree sorter.
package tree_sort_controller_pkg;

  localparam int COUNT = 6;
  localparam int IDX_W = 3;
  localparam logic [IDX_W-1:0] LAST_SLOT = IDX_W'(COUNT - 1);

  typedef enum logic [1:0] {
    ST_LOAD = 2'd0,
    ST_PICK = 2'd1,
    ST_EMIT = 2'd2
  } state_t;

  // True when exactly one slot is still untaken, i.e. this pick is the batch's last word.
  function automatic logic is_final_pick(input logic [COUNT-1:0] taken);
    return $countones(taken) == COUNT - 1;
  endfunction

endpackage

// File: rtl/tree_sort_controller_select6.sv
// Combinational 3-level pairwise tournament choosing the best untaken slot of six.
module tree_sort_controller_select6
  import tree_sort_controller_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter bit DESCEND = 1'b1
) (
  input  logic [WIDTH-1:0] data [COUNT],
  input  logic [COUNT-1:0] taken,
  output logic [WIDTH-1:0] win_data,
  output logic [IDX_W-1:0] win_index
);

  // Left operand always holds the lower slot indices, so ties stay on the left.
  function automatic logic right_wins(input logic [WIDTH-1:0] a_d, input logic a_t,
                                      input logic [WIDTH-1:0] b_d, input logic b_t);
    if (b_t) return 1'b0;
    if (a_t) return 1'b1;
    return DESCEND ? (b_d > a_d) : (b_d < a_d);
  endfunction

  logic [WIDTH-1:0] l1_d [3];
  logic [IDX_W-1:0] l1_i [3];
  logic             l1_t [3];
  logic [WIDTH-1:0] l2_d;
  logic [IDX_W-1:0] l2_i;
  logic             l2_t;

  always_comb begin
    for (int n = 0; n < 3; n++) begin
      if (right_wins(data[2*n], taken[2*n], data[2*n+1], taken[2*n+1])) begin
        l1_d[n] = data[2*n+1];
        l1_i[n] = IDX_W'(2*n+1);
        l1_t[n] = taken[2*n+1];
      end else begin
        l1_d[n] = data[2*n];
        l1_i[n] = IDX_W'(2*n);
        l1_t[n] = taken[2*n];
      end
    end
  end

  always_comb begin
    if (right_wins(l1_d[0], l1_t[0], l1_d[1], l1_t[1])) begin
      l2_d = l1_d[1];
      l2_i = l1_i[1];
      l2_t = l1_t[1];
    end else begin
      l2_d = l1_d[0];
      l2_i = l1_i[0];
      l2_t = l1_t[0];
    end
  end

  always_comb begin
    if (right_wins(l2_d, l2_t, l1_d[2], l1_t[2])) begin
      win_data  = l1_d[2];
      win_index = l1_i[2];
    end else begin
      win_data  = l2_d;
      win_index = l2_i;
    end
  end

endmodule

// File: rtl/tree_sort_controller.sv
// Loads six words, then emits them one at a time in sorted order with their load slot.
module tree_sort_controller
  import tree_sort_controller_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter bit DESCEND = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [2:0]       out_index,
  output logic             out_last,
  output logic             busy
);

  state_t state, state_next;

  logic [IDX_W-1:0] cnt;
  logic [WIDTH-1:0] slot [COUNT];
  logic [COUNT-1:0] taken;
  logic [WIDTH-1:0] win_data;
  logic [IDX_W-1:0] win_index;
  logic             accept;

  assign accept = in_valid && in_ready;

  tree_sort_controller_select6 #(
    .WIDTH   (WIDTH),
    .DESCEND (DESCEND)
  ) u_select6 (
    .data      (slot),
    .taken     (taken),
    .win_data  (win_data),
    .win_index (win_index)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_LOAD;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_LOAD: if (accept && cnt == LAST_SLOT) state_next = ST_PICK;
      ST_PICK: state_next = ST_EMIT;
      ST_EMIT: if (out_ready) state_next = out_last ? ST_LOAD : ST_PICK;
      default: state_next = ST_LOAD;
    endcase
  end

  always_comb begin
    in_ready = (state == ST_LOAD);
    busy     = (state != ST_LOAD);
  end

  // Output registers only change in PICK, so they hold naturally while EMIT stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      taken     <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
      out_index <= '0;
    end else begin
      case (state)
        ST_LOAD: begin
          if (accept) begin
            slot[cnt] <= in_data;
            cnt       <= (cnt == LAST_SLOT) ? '0 : cnt + 1'b1;
          end
        end
        ST_PICK: begin
          out_data         <= win_data;
          out_index        <= win_index;
          out_last         <= is_final_pick(taken);
          out_valid        <= 1'b1;
          taken[win_index] <= 1'b1;
        end
        ST_EMIT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (out_last) begin
              out_last <= 1'b0;
              taken    <= '0;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
